uart_rx_cfg: RTL and testbench

Parametrised UART receiver for the serial I/O subsystem, sitting between the pad-side `rx` line and the byte-stream consumer, driven by the shared baud-tick generator's oversampling `s_tick`. Supports configurable data width, oversampling ratio, stop length and parity. Adds an input synchroniser, 3-sample majority voting, false-start rejection, parity/framing/break detection and a valid/ready output holding register with overrun reporting.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_cfg_if.sv | 25 ++
 rtl/uart_rx_sampler.sv | 42 ++++
 rtl/uart_rx_cfg.sv | 205 ++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode, receiver FSM states and a 3-input majority helper.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2
   } parity_e;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      START    = 3'd1,
      DATA     = 3'd2,
      PARITY   = 3'd3,
      STOP     = 3'd4,
      BRK_WAIT = 3'd5
   } rx_state_e;

   // Majority of three samples.
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Receiver-to-consumer byte stream: valid/ready holding register, frame status and event pulses.
//   master: receiver side (drives data, status, pulses; observes rx_ready)
//   slave : consumer side (drives rx_ready)
interface uart_rx_cfg_if #(
   parameter int unsigned DBIT = 8
);
   logic            rx_valid;
   logic            rx_ready;
   logic [DBIT-1:0] dout;
   logic            parity_err;
   logic            frame_err;
   logic            break_det;
   logic            rx_done_tick;
   logic            overrun_tick;

   modport master (
      output rx_valid, dout, parity_err, frame_err, break_det, rx_done_tick, overrun_tick,
      input  rx_ready
   );

   modport slave (
      input  rx_valid, dout, parity_err, frame_err, break_det, rx_done_tick, overrun_tick,
      output rx_ready
   );
endinterface

// File: rtl/uart_rx_sampler.sv
// Line conditioning for the UART receiver: 2-flop synchroniser and 3-sample majority vote.
//   clk, reset_n : clock, async active-low reset (all flops reset to line-idle 1)
//   rx           : asynchronous serial line
//   s_tick       : oversample enable
//   rxs          : synchronised line (registered)
//   maj_c        : majority of the current and the two previous s_tick samples of rxs
module uart_rx_sampler
   import uart_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic rx,
   input  logic s_tick,
   output logic rxs,
   output logic maj_c
);

   logic sync1;
   logic rxs_q;
   logic [1:0] hist;

   // Synchroniser plus history of the two previous tick samples.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= 1'b1;
         rxs_q <= 1'b1;
         hist  <= 2'b11;
      end else begin
         sync1 <= rx;
         rxs_q <= sync1;
         if (s_tick) begin
            hist <= {hist[0], rxs_q};
         end
      end
   end

   // The third vote is the sample taken on the current tick, so a decision made
   // on tick W-1 covers ticks W-3, W-2 and W-1.
   assign maj_c = maj3(hist[1], hist[0], rxs_q);
   assign rxs   = rxs_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver with false-start rejection, parity/framing/break detection
// and a valid/ready output holding register with overrun reporting.
//   clk, reset_n : clock, async active-low reset
//   rx           : asynchronous serial line, idle high
//   s_tick       : one-cycle oversample enable from the baud generator
//   bus          : byte stream to the consumer (rx_done_tick/overrun_tick are
//                  same-cycle pulses on the final stop tick; the rest is registered)
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int unsigned DBIT    = 8,
   parameter int unsigned OVS     = 16,
   parameter int unsigned SB_TICK = 16,
   parameter parity_e     PARITY  = PAR_NONE
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          rx,
   input  logic          s_tick,
   uart_rx_cfg_if.master bus
);

   localparam int unsigned SMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
   localparam int unsigned SW   = $clog2(SMAX);
   localparam int unsigned NW   = $clog2(DBIT);

   localparam logic [SW-1:0] S_HALF = SW'(OVS / 2 - 1);
   localparam logic [SW-1:0] S_BIT  = SW'(OVS - 1);
   localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

   rx_state_e       state;
   logic [SW-1:0]   s;
   logic [NW-1:0]   n;
   logic [DBIT-1:0] b;
   logic            par_bit;
   logic            perr_q;
   logic            ferr_q;

   logic            valid_q;
   logic [DBIT-1:0] dout_q;
   logic            perr_out;
   logic            ferr_out;
   logic            brk_out;

   logic rxs;
   logic maj;

   logic frame_end_c;
   logic ferr_now_c;
   logic brk_c;
   logic load_c;
   logic overrun_c;

   uart_rx_sampler u_sampler (
      .clk     (clk),
      .reset_n (reset_n),
      .rx      (rx),
      .s_tick  (s_tick),
      .rxs     (rxs),
      .maj_c   (maj)
   );

   // Frame completion and its status as seen in the final stop tick.
   always_comb begin
      frame_end_c = 1'b0;
      ferr_now_c  = ferr_q;
      brk_c       = 1'b0;
      if ((state == uart_pkg::STOP) && s_tick && (s == S_STOP)) begin
         frame_end_c = 1'b1;
      end
      // When the stop sample and the frame end share a tick the latched flag is not yet valid.
      if (s == S_BIT) begin
         ferr_now_c = ~maj;
      end
      brk_c = (b == '0) && ((PARITY == PAR_NONE) || !par_bit) && ferr_now_c;
   end

   assign load_c    = frame_end_c && (!valid_q || bus.rx_ready);
   assign overrun_c = frame_end_c && valid_q && !bus.rx_ready;

   // Receive FSM with bit/tick counters, data shift register and parity check.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= uart_pkg::IDLE;
         s       <= '0;
         n       <= '0;
         b       <= '0;
         par_bit <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         case (state)
            uart_pkg::IDLE: begin
               if (!rxs) begin
                  state  <= uart_pkg::START;
                  s      <= '0;
                  perr_q <= 1'b0;
                  ferr_q <= 1'b0;
               end
            end
            uart_pkg::START: begin
               if (s_tick) begin
                  if (s == S_HALF) begin
                     // Line back high in mid start bit: treat as a glitch.
                     if (maj) begin
                        state <= uart_pkg::IDLE;
                     end else begin
                        state <= uart_pkg::DATA;
                        s     <= '0;
                        n     <= '0;
                     end
                  end else begin
                     s <= s + SW'(1);
                  end
               end
            end
            uart_pkg::DATA: begin
               if (s_tick) begin
                  if (s == S_BIT) begin
                     b <= {maj, b[DBIT-1:1]};
                     s <= '0;
                     if (n == N_LAST) begin
                        if (PARITY != PAR_NONE) begin
                           state <= uart_pkg::PARITY;
                        end else begin
                           state <= uart_pkg::STOP;
                        end
                     end else begin
                        n <= n + NW'(1);
                     end
                  end else begin
                     s <= s + SW'(1);
                  end
               end
            end
            uart_pkg::PARITY: begin
               if (s_tick) begin
                  if (s == S_BIT) begin
                     par_bit <= maj;
                     perr_q  <= ((^b) ^ maj) != (PARITY == PAR_ODD);
                     state   <= uart_pkg::STOP;
                     s       <= '0;
                  end else begin
                     s <= s + SW'(1);
                  end
               end
            end
            uart_pkg::STOP: begin
               if (s_tick) begin
                  if (s == S_BIT) begin
                     ferr_q <= ~maj;
                  end
                  if (s == S_STOP) begin
                     s <= '0;
                     if (brk_c) begin
                        state <= uart_pkg::BRK_WAIT;
                     end else begin
                        state <= uart_pkg::IDLE;
                     end
                  end else begin
                     s <= s + SW'(1);
                  end
               end
            end
            uart_pkg::BRK_WAIT: begin
               if (rxs) begin
                  state <= uart_pkg::IDLE;
               end
            end
            default: begin
               state <= uart_pkg::IDLE;
            end
         endcase
      end
   end

   // Output holding register; data and status only change on a load.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q  <= 1'b0;
         dout_q   <= '0;
         perr_out <= 1'b0;
         ferr_out <= 1'b0;
         brk_out  <= 1'b0;
      end else if (load_c) begin
         valid_q  <= 1'b1;
         dout_q   <= b;
         perr_out <= perr_q;
         ferr_out <= ferr_now_c;
         brk_out  <= brk_c;
      end else if (valid_q && bus.rx_ready) begin
         valid_q <= 1'b0;
      end
   end

   assign bus.rx_valid     = valid_q;
   assign bus.dout         = dout_q;
   assign bus.parity_err   = perr_out;
   assign bus.frame_err    = ferr_out;
   assign bus.break_det    = brk_out;
   assign bus.rx_done_tick = frame_end_c;
   assign bus.overrun_tick = overrun_c;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: an 8N1 instance (a) and an 8E1 instance (b).
module tb_uart_rx_cfg;
   import uart_pkg::*;

   localparam int unsigned TDIV   = 4;
   localparam int unsigned OVS    = 16;
   localparam int unsigned BITCLK = OVS * TDIV;

   typedef struct packed {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
      logic       brk;
   } exp_t;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   logic s_tick  = 1'b0;
   logic rx_a    = 1'b1;
   logic rx_b    = 1'b1;

   exp_t q_a[$];
   exp_t q_b[$];

   int n_checks = 0;
   int n_fail   = 0;
   int done_a = 0, done_b = 0, ovr_a = 0, ovr_b = 0;
   int exp_done_a = 0, exp_done_b = 0, exp_ovr_a = 0;

   uart_rx_cfg_if #(.DBIT(8)) bus_a ();
   uart_rx_cfg_if #(.DBIT(8)) bus_b ();

   uart_rx_cfg #(.DBIT(8), .OVS(OVS), .SB_TICK(16), .PARITY(PAR_NONE)) dut_a (
      .clk     (clk),
      .reset_n (reset_n),
      .rx      (rx_a),
      .s_tick  (s_tick),
      .bus     (bus_a.master)
   );

   uart_rx_cfg #(.DBIT(8), .OVS(OVS), .SB_TICK(16), .PARITY(PAR_EVEN)) dut_b (
      .clk     (clk),
      .reset_n (reset_n),
      .rx      (rx_b),
      .s_tick  (s_tick),
      .bus     (bus_b.master)
   );

   always #5 clk = ~clk;

   // One s_tick every TDIV clocks.
   initial begin
      forever begin
         repeat (TDIV - 1) @(posedge clk);
         #1 s_tick = 1'b1;
         @(posedge clk);
         #1 s_tick = 1'b0;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   // Monitors: count pulses and pop/compare on every accepted beat.
   always begin
      exp_t e;
      @(negedge clk);
      #1;
      if (reset_n) begin
         if (bus_a.rx_done_tick) done_a++;
         if (bus_a.overrun_tick) ovr_a++;
         if (bus_a.rx_valid && bus_a.rx_ready) begin
            if (q_a.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL a_unexpected_beat: got dout 0x%0h with empty scoreboard", bus_a.dout);
            end else begin
               e = q_a.pop_front();
               check("a_dout", 32'(bus_a.dout), 32'(e.data));
               check("a_flags{p,f,b}", 32'({bus_a.parity_err, bus_a.frame_err, bus_a.break_det}),
                     32'({e.perr, e.ferr, e.brk}));
            end
         end
      end
   end

   always begin
      exp_t e;
      @(negedge clk);
      #1;
      if (reset_n) begin
         if (bus_b.rx_done_tick) done_b++;
         if (bus_b.overrun_tick) ovr_b++;
         if (bus_b.rx_valid && bus_b.rx_ready) begin
            if (q_b.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL b_unexpected_beat: got dout 0x%0h with empty scoreboard", bus_b.dout);
            end else begin
               e = q_b.pop_front();
               check("b_dout", 32'(bus_b.dout), 32'(e.data));
               check("b_flags{p,f,b}", 32'({bus_b.parity_err, bus_b.frame_err, bus_b.break_det}),
                     32'({e.perr, e.ferr, e.brk}));
            end
         end
      end
   end

   task automatic wait_clk(input int unsigned cycles);
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   task automatic set_rx(input bit sel, input logic v);
      if (sel) rx_b = v;
      else     rx_a = v;
   endtask

   task automatic push(input bit sel, input logic [7:0] d, input logic p, input logic f, input logic k);
      exp_t e;
      e.data = d;
      e.perr = p;
      e.ferr = f;
      e.brk  = k;
      if (sel) q_b.push_back(e);
      else     q_a.push_back(e);
   endtask

   // One frame: start, 8 data bits LSB first, optional parity, stop, one idle bit.
   // A low stop bit is held only 40 clk so the line is high again before a new start could be accepted.
   task automatic send_frame(input bit sel, input logic [7:0] d, input bit par_en, input logic par,
                             input bit stop_low, input int glitch_bit);
      set_rx(sel, 1'b0);
      wait_clk(BITCLK);
      for (int i = 0; i < 8; i++) begin
         set_rx(sel, d[i]);
         if (i == glitch_bit) begin
            wait_clk(30);
            set_rx(sel, ~d[i]);
            wait_clk(TDIV);
            set_rx(sel, d[i]);
            wait_clk(BITCLK - 30 - TDIV);
         end else begin
            wait_clk(BITCLK);
         end
      end
      if (par_en) begin
         set_rx(sel, par);
         wait_clk(BITCLK);
      end
      if (stop_low) begin
         set_rx(sel, 1'b0);
         wait_clk(40);
         set_rx(sel, 1'b1);
         wait_clk(BITCLK - 40);
      end else begin
         set_rx(sel, 1'b1);
         wait_clk(BITCLK);
      end
      wait_clk(BITCLK);
      if (sel) exp_done_b++;
      else     exp_done_a++;
   endtask

   initial begin
      bit hit;
      bus_a.rx_ready = 1'b1;
      bus_b.rx_ready = 1'b1;

      // Reset state.
      wait_clk(5);
      check("a_reset_valid", 32'(bus_a.rx_valid), 32'd0);
      check("a_reset_dout", 32'(bus_a.dout), 32'd0);
      check("a_reset_flags", 32'({bus_a.parity_err, bus_a.frame_err, bus_a.break_det}), 32'd0);
      check("a_reset_pulses", 32'({bus_a.rx_done_tick, bus_a.overrun_tick}), 32'd0);
      check("b_reset_valid", 32'(bus_b.rx_valid), 32'd0);
      check("b_reset_dout", 32'(bus_b.dout), 32'd0);
      reset_n = 1'b1;
      wait_clk(BITCLK);

      // 8N1 basic bytes.
      push(0, 8'h55, 0, 0, 0); send_frame(0, 8'h55, 0, 1'b0, 0, -1);
      push(0, 8'hA3, 0, 0, 0); send_frame(0, 8'hA3, 0, 1'b0, 0, -1);

      // 8E1: 0x07 has three ones, so the even parity bit must be 1.
      push(1, 8'h07, 1, 0, 0); send_frame(1, 8'h07, 1, 1'b0, 0, -1);
      push(1, 8'h07, 0, 0, 0); send_frame(1, 8'h07, 1, 1'b1, 0, -1);
      push(1, 8'hA3, 0, 0, 0); send_frame(1, 8'hA3, 1, 1'b0, 0, -1);

      // False start: 4 ticks low is rejected at mid start bit.
      set_rx(0, 1'b0);
      wait_clk(4 * TDIV);
      set_rx(0, 1'b1);
      wait_clk(3 * BITCLK);
      check("a_false_start_no_done", 32'(done_a), 32'(exp_done_a));
      check("a_false_start_no_valid", 32'(bus_a.rx_valid), 32'd0);

      // One-tick glitch inside data bit 2 is outvoted.
      push(0, 8'hC6, 0, 0, 0); send_frame(0, 8'hC6, 0, 1'b0, 0, 2);

      // Framing error without break.
      push(0, 8'h3C, 0, 1, 0); send_frame(0, 8'h3C, 0, 1'b0, 1, -1);

      // Break: line low for 12 bit times yields exactly one frame.
      push(0, 8'h00, 0, 1, 1);
      set_rx(0, 1'b0);
      wait_clk(12 * BITCLK);
      exp_done_a++;
      check("a_break_single_done", 32'(done_a), 32'(exp_done_a));
      set_rx(0, 1'b1);
      wait_clk(2 * BITCLK);
      check("a_break_release_no_done", 32'(done_a), 32'(exp_done_a));

      // Overrun: second frame dropped while the first is held.
      bus_a.rx_ready = 1'b0;
      push(0, 8'h11, 0, 0, 0); send_frame(0, 8'h11, 0, 1'b0, 0, -1);
      send_frame(0, 8'h22, 0, 1'b0, 0, -1);
      exp_ovr_a++;
      check("a_overrun_count", 32'(ovr_a), 32'(exp_ovr_a));
      check("a_overrun_hold_dout", 32'(bus_a.dout), 32'h11);
      check("a_overrun_hold_valid", 32'(bus_a.rx_valid), 32'd1);
      bus_a.rx_ready = 1'b1;
      wait_clk(1);
      bus_a.rx_ready = 1'b0;
      wait_clk(4);
      check("a_drained_valid", 32'(bus_a.rx_valid), 32'd0);

      // rx_ready pulsed in the completion cycle of the next frame: no overrun.
      push(0, 8'h33, 0, 0, 0); send_frame(0, 8'h33, 0, 1'b0, 0, -1);
      push(0, 8'h44, 0, 0, 0);
      hit = 1'b0;
      fork
         send_frame(0, 8'h44, 0, 1'b0, 0, -1);
         begin
            for (int i = 0; i < 14 * int'(BITCLK); i++) begin
               @(negedge clk);
               if (bus_a.rx_done_tick) begin
                  bus_a.rx_ready = 1'b1;
                  @(posedge clk);
                  #1 bus_a.rx_ready = 1'b0;
                  hit = 1'b1;
                  break;
               end
            end
         end
      join
      check("a_coincident_done_seen", 32'(hit), 32'd1);
      check("a_coincident_no_overrun", 32'(ovr_a), 32'(exp_ovr_a));
      check("a_coincident_dout", 32'(bus_a.dout), 32'h44);
      bus_a.rx_ready = 1'b1;
      wait_clk(4);

      // Reset in mid DATA aborts the frame silently.
      set_rx(0, 1'b0);
      wait_clk(4 * BITCLK);
      reset_n = 1'b0;
      wait_clk(3);
      check("a_midreset_valid", 32'(bus_a.rx_valid), 32'd0);
      check("a_midreset_dout", 32'(bus_a.dout), 32'd0);
      set_rx(0, 1'b1);
      wait_clk(2);
      reset_n = 1'b1;
      wait_clk(2 * BITCLK);
      check("a_midreset_no_done", 32'(done_a), 32'(exp_done_a));
      push(0, 8'h81, 0, 0, 0); send_frame(0, 8'h81, 0, 1'b0, 0, -1);
      check("a_after_reset_dout", 32'(bus_a.dout), 32'h81);

      // Final accounting.
      wait_clk(2 * BITCLK);
      check("a_queue_empty", 32'(q_a.size()), 32'd0);
      check("b_queue_empty", 32'(q_b.size()), 32'd0);
      check("a_done_count", 32'(done_a), 32'(exp_done_a));
      check("b_done_count", 32'(done_b), 32'(exp_done_b));
      check("a_overrun_total", 32'(ovr_a), 32'(exp_ovr_a));
      check("b_overrun_total", 32'(ovr_b), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
